alu_exec: RTL and testbench
===========================

# alu_exec

Execution-stage ALU that consumes the 4-bit `aluctl` code produced by the ALU control decoder and returns a registered result with flags. Sits between the register-read stage and writeback, with a valid/ready handshake on both sides. Single-cycle operations complete in one clock. An optional iterative multiplier (compile-time) makes the block multi-cycle.

## Interface
- `DW`, 32, operand/result width; the multiplier iteration count equals `DW`.
- `clk`  input  1  sole clock, rising-edge.
- `rst_n`  input  1  asynchronous, active-low reset.
- `aluctl`  input  4  operation code, sampled on accept.
- `a`  input  DW  operand A, sampled on accept.
- `b`  input  DW  operand B, sampled on accept.
- `in_valid`  input  1  request present.
- `in_ready`  output  1  block can accept a request this cycle.
- `out_valid`  output  1  result/flags valid.
- `out_ready`  input  1  consumer takes the result this cycle.
- `result`  output  DW  registered result.
- `zero`  output  1  `result == 0`.
- `ovf`  output  1  signed overflow (add/sub only).
- `illegal`  output  1  the `aluctl` code is unsupported.

## Operation
- Codes: 0 AND, 1 OR, 2 ADD, 6 SUB, 7 SLT (signed), 12 NOR, 13 XOR, 3 MUL (only with the macro). All other codes are illegal.
- Arithmetic is modulo 2^DW, two's complement.
- SLT: `result = {DW-1 zeros, (a-b)[DW-1] ^ ovf_sub}`. `ovf` is forced to 0 for SLT.
- ADD `ovf`: a and b have the same sign, and the result sign differs. SUB `ovf`: a and b have different signs, and the result sign differs from a.
- Illegal code: `result` = 0, `zero` = 1, `ovf` = 0, `illegal` = 1. Completes with single-cycle latency.
- MUL: unsigned shift-add producing the low DW bits of a*b. One partial product per cycle. `ovf` = 0.
- FSM states:
  - IDLE → DONE on accept of a single-cycle op.
  - IDLE → MUL on accept of code 3.
  - MUL → DONE when the iteration counter reaches DW-1.
  - DONE → IDLE on `out_ready` with no new accept.
  - DONE → DONE or MUL on `out_ready` plus a new accept.
- Accept: `in_valid & in_ready`.
- `in_ready = (state==IDLE) | (state==DONE & out_ready)`. This is a combinational path from `out_ready`, and it allows back-to-back issue.
- In DONE with `out_ready` low, `result`/`zero`/`ovf`/`illegal` stay stable. `in_valid` is ignored.
- During MUL, `in_ready` = 0 and `out_valid` = 0. Inputs are not re-sampled.

## Timing
- Reset values: state IDLE, `out_valid` 0, `result` 0, `zero` 0, `ovf` 0, `illegal` 0, MUL counter 0.
- `in_ready` is 1 after reset.
- Single-cycle op accepted at edge N: `out_valid` = 1 with final values after edge N. Latency is 1 cycle.
- MUL accepted at edge N: iterations run at edges N+1 … N+DW. `out_valid` rises after edge N+DW.
- Back-to-back: `out_valid` stays 1 across the handoff edge, and the outputs update to the new op.
- An operand change after accept has no effect on an in-flight op.
- `rst_n` asserted mid-MUL or in DONE: immediate return to reset values. The in-flight result is discarded.
- `zero` and `ovf` are registered together with `result`, with no skew.

## Configuration
- `ALU_EXEC_MUL_EN` defined:
  - code 3 = iterative MUL.
  - MUL state, counter and accumulator are present.
- `ALU_EXEC_MUL_EN` undefined:
  - code 3 is illegal (`illegal` = 1, result 0, 1-cycle latency).
  - MUL state and datapath are absent; the FSM has IDLE and DONE only.

## Test plan
- Reset release, `out_ready` = 1:
  - ADD a=0x7FFFFFFF, b=1 → next cycle result 0x80000000, `ovf` = 1, `zero` = 0.
  - SUB 5−5 → result 0, `zero` = 1, `ovf` = 0.
- SLT a=0xFFFFFFFF, b=1 → 1. SLT a=0x80000000, b=0x7FFFFFFF → 1. SLT a=1, b=0xFFFFFFFF → 0.
- Illegal code 4'd9 → result 0, `illegal` = 1, 1-cycle latency. Code 3 without the macro → same response.
- Backpressure: hold `out_ready` = 0 for 5 cycles after XOR 0xF0F0F0F0 ^ 0x0FF00FF0. Required:
  - `result` holds 0xFF00FF00.
  - `in_ready` = 0.
  - A second request is accepted only on the cycle `out_ready` = 1.
- Macro on, MUL 12345×6789:
  - `out_valid` exactly DW cycles after accept, with result 83810205.
  - `in_ready` = 0 throughout.
  - MUL 0xFFFFFFFF×2 → 0xFFFFFFFE.
- Assert `rst_n` = 0 at iteration 10 of a MUL:
  - All outputs go to reset values immediately.
  - After release, AND 0xFF & 0x0F → 0x0F with 1-cycle latency.

Source files
------------

// File: rtl/alu_exec.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : alu_exec
// Purpose  : Execution-stage ALU with valid/ready handshake and registered
//            result/flags. Define ALU_EXEC_MUL_EN to add the iterative MUL.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
module alu_exec #(
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [3:0]    aluctl,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  logic          in_valid,
  output logic          in_ready,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] result,
  output logic          zero,
  output logic          ovf,
  output logic          illegal
);

  localparam logic [3:0] c_OP_AND = 4'd0;
  localparam logic [3:0] c_OP_OR  = 4'd1;
  localparam logic [3:0] c_OP_ADD = 4'd2;
  localparam logic [3:0] c_OP_MUL = 4'd3;
  localparam logic [3:0] c_OP_SUB = 4'd6;
  localparam logic [3:0] c_OP_SLT = 4'd7;
  localparam logic [3:0] c_OP_NOR = 4'd12;
  localparam logic [3:0] c_OP_XOR = 4'd13;

`ifdef ALU_EXEC_MUL_EN
  localparam int CW = (DW > 1) ? $clog2(DW) : 1;
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DONE = 2'd1,
    ST_MUL  = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DONE = 2'd1
  } state_t;
`endif

  state_t        r_state;
  logic          r_out_valid;
  logic [DW-1:0] r_result;
  logic          r_zero;
  logic          r_ovf;
  logic          r_illegal;

  logic [DW-1:0] w_sum;
  logic [DW-1:0] w_diff;
  logic          w_ovf_add;
  logic          w_ovf_sub;
  logic [DW-1:0] w_res;
  logic          w_ovf;
  logic          w_illegal;
  logic          w_accept;

  assign w_sum     = a + b;
  assign w_diff    = a - b;
  assign w_ovf_add = (a[DW-1] == b[DW-1]) & (w_sum[DW-1]  != a[DW-1]);
  assign w_ovf_sub = (a[DW-1] != b[DW-1]) & (w_diff[DW-1] != a[DW-1]);

  assign in_ready  = (r_state == ST_IDLE) | ((r_state == ST_DONE) & out_ready);
  assign w_accept  = in_valid & in_ready;

  assign out_valid = r_out_valid;
  assign result    = r_result;
  assign zero      = r_zero;
  assign ovf       = r_ovf;
  assign illegal   = r_illegal;

`ifdef ALU_EXEC_MUL_EN
  logic          w_is_mul;
  logic [CW-1:0] r_cnt;
  logic [DW-1:0] r_acc;
  logic [DW-1:0] r_mcand;
  logic [DW-1:0] r_mplier;
  logic [DW-1:0] w_acc_next;

  // One partial product per cycle: multiplicand shifts left, multiplier right.
  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);
`endif

  always_comb begin
    w_res     = '0;
    w_ovf     = 1'b0;
    w_illegal = 1'b0;
`ifdef ALU_EXEC_MUL_EN
    w_is_mul  = 1'b0;
`endif
    case (aluctl)
      c_OP_AND: w_res = a & b;
      c_OP_OR:  w_res = a | b;
      c_OP_ADD: begin
        w_res = w_sum;
        w_ovf = w_ovf_add;
      end
      c_OP_SUB: begin
        w_res = w_diff;
        w_ovf = w_ovf_sub;
      end
      // Signed compare: the true sign of a-b is the raw sign corrected by overflow.
      c_OP_SLT: w_res = {{(DW-1){1'b0}}, w_diff[DW-1] ^ w_ovf_sub};
      c_OP_NOR: w_res = ~(a | b);
      c_OP_XOR: w_res = a ^ b;
`ifdef ALU_EXEC_MUL_EN
      c_OP_MUL: w_is_mul  = 1'b1;
`else
      c_OP_MUL: w_illegal = 1'b1;
`endif
      default:  w_illegal = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= ST_IDLE;
      r_out_valid <= 1'b0;
      r_result    <= '0;
      r_zero      <= 1'b0;
      r_ovf       <= 1'b0;
      r_illegal   <= 1'b0;
`ifdef ALU_EXEC_MUL_EN
      r_cnt       <= '0;
      r_acc       <= '0;
      r_mcand     <= '0;
      r_mplier    <= '0;
`endif
    end else if (w_accept) begin
`ifdef ALU_EXEC_MUL_EN
      if (w_is_mul) begin
        r_state     <= ST_MUL;
        r_out_valid <= 1'b0;
        r_cnt       <= '0;
        r_acc       <= '0;
        r_mcand     <= a;
        r_mplier    <= b;
      end else begin
`endif
        r_state     <= ST_DONE;
        r_out_valid <= 1'b1;
        r_result    <= w_res;
        r_zero      <= (w_res == '0);
        r_ovf       <= w_ovf;
        r_illegal   <= w_illegal;
`ifdef ALU_EXEC_MUL_EN
      end
`endif
    end else begin
      case (r_state)
        ST_DONE: begin
          if (out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
          end
        end
`ifdef ALU_EXEC_MUL_EN
        ST_MUL: begin
          r_acc    <= w_acc_next;
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CW'(1);
          if (r_cnt == CW'(DW-1)) begin
            r_state     <= ST_DONE;
            r_out_valid <= 1'b1;
            r_result    <= w_acc_next;
            r_zero      <= (w_acc_next == '0);
            r_ovf       <= 1'b0;
            r_illegal   <= 1'b0;
            r_cnt       <= '0;
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_exec.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : tb_alu_exec
// Purpose  : Directed self-checking bench for alu_exec (MUL tests run only
//            when ALU_EXEC_MUL_EN is defined).
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
module tb_alu_exec;
  localparam int DW = 32;

  logic          clk;
  logic          rst_n;
  logic [3:0]    aluctl;
  logic [DW-1:0] a;
  logic [DW-1:0] b;
  logic          in_valid;
  logic          in_ready;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] result;
  logic          zero;
  logic          ovf;
  logic          illegal;

  int checks   = 0;
  int failures = 0;

  alu_exec #(.DW(DW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .aluctl    (aluctl),
    .a         (a),
    .b         (b),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .zero      (zero),
    .ovf       (ovf),
    .illegal   (illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Issues one request back-to-back and checks the 1-cycle-latency response.
  // Flags packed as {out_valid, zero, ovf, illegal}.
  task automatic do_op(input string tag, input logic [3:0] ctl, input logic [31:0] va,
                       input logic [31:0] vb, input logic [31:0] exp_res, input logic [3:0] exp_flags);
    @(negedge clk);
    aluctl = ctl; a = va; b = vb; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    check({tag, ".in_ready"}, {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check({tag, ".result"}, result, exp_res);
    check({tag, ".flags"}, {28'd0, out_valid, zero, ovf, illegal}, {28'd0, exp_flags});
  endtask

  initial begin
    rst_n = 1'b0; aluctl = 4'd0; a = '0; b = '0; in_valid = 1'b0; out_ready = 1'b1;
    #12;
    check("reset.result", result, 32'd0);
    check("reset.flags", {28'd0, out_valid, zero, ovf, illegal}, 32'd0);
    check("reset.in_ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk); rst_n = 1'b1;

    do_op("add_ovf", 4'd2,  32'h7FFFFFFF, 32'h1,        32'h80000000, 4'b1010);
    do_op("sub_zero", 4'd6, 32'd5,        32'd5,        32'h0,        4'b1100);
    do_op("sub_ovf", 4'd6,  32'h80000000, 32'h1,        32'h7FFFFFFF, 4'b1010);
    do_op("slt_m1_1", 4'd7, 32'hFFFFFFFF, 32'h1,        32'h1,        4'b1000);
    do_op("slt_min_max", 4'd7, 32'h80000000, 32'h7FFFFFFF, 32'h1,     4'b1000);
    do_op("slt_1_m1", 4'd7, 32'h1,        32'hFFFFFFFF, 32'h0,        4'b1100);
    do_op("and", 4'd0,      32'hFF00FF00, 32'h0FF00FF0, 32'h0F000F00, 4'b1000);
    do_op("or", 4'd1,       32'hF0000000, 32'h0000000F, 32'hF000000F, 4'b1000);
    do_op("nor", 4'd12,     32'h0,        32'h0,        32'hFFFFFFFF, 4'b1000);
    do_op("illegal9", 4'd9, 32'h12345678, 32'h1,        32'h0,        4'b1101);
`ifndef ALU_EXEC_MUL_EN
    do_op("illegal3", 4'd3, 32'd12345,    32'd6789,     32'h0,        4'b1101);
`endif

    // Consumer takes the last result with nothing new: block goes idle.
    @(negedge clk); out_ready = 1'b1; in_valid = 1'b0;
    @(posedge clk); #1;
    check("idle.out_valid", {31'd0, out_valid}, 32'd0);

    // Backpressure: XOR result must hold while a second request waits.
    do_op("xor", 4'd13, 32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00, 4'b1000);
    out_ready = 1'b0; in_valid = 1'b1; aluctl = 4'd2; a = 32'd3; b = 32'd4;
    begin
      int bad = 0;
      for (int i = 0; i < 5; i++) begin
        #1;
        if (result !== 32'hFF00FF00 || in_ready !== 1'b0 || out_valid !== 1'b1) bad++;
        @(posedge clk); #1;
      end
      check("bp.hold", bad, 32'd0);
    end
    check("bp.result", result, 32'hFF00FF00);
    @(negedge clk); out_ready = 1'b1;
    #1;
    check("bp.in_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("bp.second", result, 32'd7);

`ifdef ALU_EXEC_MUL_EN
    begin
      int n;
      int busy;
      do_op("and_pre", 4'd0, 32'h1, 32'h1, 32'h1, 4'b1000);
      @(negedge clk); aluctl = 4'd3; a = 32'd12345; b = 32'd6789; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b1; aluctl = 4'd2; a = 32'hDEAD; b = 32'hBEEF;
      n = 0; busy = 0;
      while (out_valid !== 1'b1 && n < 100) begin
        if (in_ready !== 1'b0) busy++;
        @(posedge clk); #1;
        n++;
      end
      in_valid = 1'b0;
      check("mul.latency", n, DW);
      check("mul.in_ready_low", busy, 32'd0);
      check("mul.result", result, 32'd83810205);
      check("mul.flags", {28'd0, out_valid, zero, ovf, illegal}, 32'b1000);

      @(negedge clk); aluctl = 4'd3; a = 32'hFFFFFFFF; b = 32'd2; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      n = 0;
      while (out_valid !== 1'b1 && n < 100) begin
        @(posedge clk); #1;
        n++;
      end
      check("mul2.latency", n, DW);
      check("mul2.result", result, 32'hFFFFFFFE);

      // Reset in the middle of a multiply.
      @(negedge clk); aluctl = 4'd3; a = 32'd7; b = 32'd9; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      for (int i = 0; i < 10; i++) begin
        @(posedge clk); #1;
      end
      rst_n = 1'b0;
      #1;
      check("mulrst.result", result, 32'd0);
      check("mulrst.flags", {28'd0, out_valid, zero, ovf, illegal}, 32'd0);
      check("mulrst.in_ready", {31'd0, in_ready}, 32'd1);
      @(negedge clk); rst_n = 1'b1;
    end
`else
    // Reset while a result is waiting in DONE.
    @(negedge clk); out_ready = 1'b0; aluctl = 4'd1; a = 32'h5; b = 32'h2; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("donerst.pre", result, 32'h7);
    rst_n = 1'b0;
    #1;
    check("donerst.result", result, 32'd0);
    check("donerst.flags", {28'd0, out_valid, zero, ovf, illegal}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
`endif

    do_op("and_post", 4'd0, 32'hFF, 32'h0F, 32'h0F, 4'b1000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
endmodule
`default_nettype wire
